ahb_fifo_mc: RTL
================

# ahb_fifo_mc

Multi-channel, AHB-readable sample FIFO that buffers filter outputs for software. Each of NCH producers (filter output lanes) pushes SWIDTH-bit samples into its own DEPTH-entry circular buffer. An AHB-Lite slave exposes per-channel DATA (pop), STATUS and CTRL registers. Compared with the single-channel FIFO it adds channel count, a selectable overflow policy, sticky overflow, flush, and an optional level interrupt.

## Interface
- NCH, 2, number of independent channels (1..16)
- DEPTH, 8, entries per channel; power of two ≥2, else elaboration `$error`
- SWIDTH, 12, sample width; 1..31
- HADDR_W, 8, AHB address bits decoded; must be ≥ 4+clog2(NCH)
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- hsel, hwrite, hready  in  1  AHB-Lite slave controls
- haddr  in  HADDR_W  address
- hsize  in  3  transfer size (ignored, all accesses treated as word)
- htrans  in  2  transfer type; only NONSEQ/SEQ (htrans[1]=1) are acted on
- hwdata  in  32  write data
- hreadyout  out  1  constant 1 (zero wait states)
- hresp  out  1  constant 0 (OKAY)
- hrdata  out  32  read data
- wr_data  in  NCH*SWIDTH  channel c sample at [c*SWIDTH +: SWIDTH]
- wr_en  in  NCH  push strobe per channel
- irq  out  1  level interrupt (see Configuration)

## Operation
- Address map: channel = haddr[HADDR_W-1:4], register = haddr[3:2]. Offsets: 0x0 DATA (RO, read pops), 0x4 STATUS, 0x8 CTRL, 0xC reserved (reads 0). Channel ≥ NCH: reads 0, writes ignored.
- Address phase registered (hsel, haddr, hwrite, htrans) when hready=1. Reset clears the registered htrans.
- DATA read: hrdata = {valid, zeros, sample}, with bit31 = 1 when the channel is non-empty. On an empty read, hrdata = 0 and no pointer moves.
- STATUS: [15:0] count (zero-extended), [16] empty, [17] full, [18] ovf sticky. Writing 1 to bit18 clears it.
- CTRL: [0] mode (0 = overwrite oldest, 1 = drop new); [1] flush, write 1, self-clearing, reads 0; [15:8] thr (irq level, 0 = disabled).
- Pointers are clog2(DEPTH)+1 bits wide. empty = (w==r). full = MSBs differ and LSBs are equal. count = w−r, modulo 2^(AW+1).
- Push when full:
  - mode 0: store the sample, advance both pointers, set ovf.
  - mode 1: discard the sample, set ovf.
- Push and pop on the same channel in the same cycle: both take effect and count is unchanged. This holds even when full, with no ovf and no drop.
- Push and pop on an empty channel in the same cycle: the push happens, the pop is ignored (the read returns invalid).
- Flush: clears the pointers and ovf in the cycle hwdata is sampled. A push in that same cycle is discarded (flush wins). mode/thr take the written values.
- Reads of STATUS/CTRL and any write have no FIFO side effect other than those listed above.
- Outside a valid read data phase, hrdata = 0.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, irq=0, pointers=0, ovf=0, mode=0, thr=0.
- DATA read: hrdata is combinational during the data phase and shows the head entry. rptr advances on the clock edge that ends the data phase (the next edge with hready=1).
- Register writes: hwdata is sampled on the edge ending the data phase. The new value is visible to an access whose data phase starts the following cycle.
- Push: sample written on the clk edge with wr_en[c]=1. Visible to a DATA data phase in the next cycle.
- Back-to-back DATA reads pop consecutive entries, one per cycle.
- Async reset mid-transfer aborts it. The next transfer after reset release is decoded normally.

## Configuration
- `AHB_FIFO_MC_IRQ_EN` defined:
  - irq is registered and asserts one cycle after any channel has (thr≠0 and count ≥ thr) or ovf=1.
  - irq deasserts one cycle after no channel satisfies that condition.
- `AHB_FIFO_MC_IRQ_EN` undefined:
  - irq is tied to 0.
  - CTRL[15:8] is not stored and reads 0.

## Test plan
- Reset, then read ch0 DATA → 0x0000_0000; ch0 STATUS → 0x0001_0000 (empty).
- Push ch1 samples 0x123, 0x456, 0x789, then read ch1 DATA three times → 0x8000_0123, 0x8000_0456, 0x8000_0789. A fourth read → 0x0.
- DEPTH=8, mode 0: push ch0 values 1..10 → STATUS = 0x0006_0008 (full, ovf, count 8). Reads return 3..10.
- Mode 1: same 10 pushes → reads return 1..8. Write STATUS=0x0004_0000 → ovf clears.
- ch0 full, push and DATA pop in the same cycle → count stays 8, ovf stays 0, the popped value is the old head.
- With `AHB_FIFO_MC_IRQ_EN`: CTRL=0x0000_0300 (thr=3). Three pushes → irq=1 one cycle after the third. One pop → irq=0. Write CTRL bit1 (flush) → count 0, irq stays 0.

Source files
------------

// File: rtl/ahb_fifo_mc_if.sv
// AHB-Lite slave signal bundle for ahb_fifo_mc; the master modport drives the request,
// the slave modport returns hreadyout/hresp/hrdata.
interface ahb_fifo_mc_if #(
  parameter int HADDR_W = 8
);
  logic               hsel;
  logic               hwrite;
  logic               hready;
  logic [HADDR_W-1:0] haddr;
  logic [2:0]         hsize;
  logic [1:0]         htrans;
  logic [31:0]        hwdata;
  logic               hreadyout;
  logic               hresp;
  logic [31:0]        hrdata;

  modport master (
    output hsel, hwrite, hready, haddr, hsize, htrans, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, hwrite, hready, haddr, hsize, htrans, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_fifo_mc.sv
// Multi-channel sample FIFO with per-channel DATA/STATUS/CTRL over zero-wait AHB-Lite.
// Optional level interrupt and CTRL threshold storage: define AHB_FIFO_MC_IRQ_EN.
module ahb_fifo_mc #(
  parameter int NCH     = 2,
  parameter int DEPTH   = 8,
  parameter int SWIDTH  = 12,
  parameter int HADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ahb_fifo_mc_if.slave           bus,
  input  logic [NCH*SWIDTH-1:0]  wr_data,
  input  logic [NCH-1:0]         wr_en,
  output logic                   irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = HADDR_W - 4;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ahb_fifo_mc: DEPTH must be a power of two >= 2");
  end
  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("ahb_fifo_mc: NCH must be 1..16");
  end
  if (SWIDTH < 1 || SWIDTH > 31) begin : g_bad_swidth
    $error("ahb_fifo_mc: SWIDTH must be 1..31");
  end
  if (HADDR_W < 4 + $clog2(NCH)) begin : g_bad_haddr
    $error("ahb_fifo_mc: HADDR_W too small for NCH");
  end

  // Registered address phase
  logic          ap_sel, ap_write, ap_trans;
  logic [CW-1:0] ap_ch;
  logic [1:0]    ap_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ap_sel   <= 1'b0;
      ap_write <= 1'b0;
      ap_trans <= 1'b0;
      ap_ch    <= '0;
      ap_reg   <= '0;
    end else if (bus.hready) begin
      ap_sel   <= bus.hsel;
      ap_write <= bus.hwrite;
      ap_trans <= bus.htrans[1];
      ap_ch    <= bus.haddr[HADDR_W-1:4];
      ap_reg   <= bus.haddr[3:2];
    end
  end

  logic dp_act, ch_ok, rd_act, wr_act, pop_req;
  assign dp_act  = ap_sel & ap_trans;
  assign ch_ok   = 32'(ap_ch) < NCH;
  assign rd_act  = dp_act & ~ap_write & ch_ok;
  assign wr_act  = dp_act & ap_write & ch_ok & bus.hready;
  assign pop_req = rd_act & bus.hready & (ap_reg == REG_DATA);

  // Per-channel state
  logic [SWIDTH-1:0] mem   [NCH][DEPTH];
  logic [AW:0]       wptr  [NCH];
  logic [AW:0]       rptr  [NCH];
  logic [AW:0]       cnt   [NCH];
  logic [7:0]        thr_q [NCH];
  logic [NCH-1:0]    ovf, mode;
  logic [NCH-1:0]    hit, emp, ful, pop, flush, ovf_clr, ctrl_we, push;
  logic [NCH-1:0]    wr_mem, adv_r, set_ovf;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      hit[c]     = (32'(ap_ch) == c);
      cnt[c]     = wptr[c] - rptr[c];
      emp[c]     = (wptr[c] == rptr[c]);
      ful[c]     = (wptr[c][AW] != rptr[c][AW]) && (wptr[c][AW-1:0] == rptr[c][AW-1:0]);
      pop[c]     = pop_req & hit[c] & ~emp[c];
      ctrl_we[c] = wr_act & hit[c] & (ap_reg == REG_CTRL);
      flush[c]   = ctrl_we[c] & bus.hwdata[1];
      ovf_clr[c] = wr_act & hit[c] & (ap_reg == REG_STAT) & bus.hwdata[18];
      push[c]    = wr_en[c] & ~flush[c];
      // A simultaneous pop makes room, so a push onto a full channel is not an overflow
      wr_mem[c]  = push[c] & (pop[c] | ~ful[c] | ~mode[c]);
      set_ovf[c] = push[c] & ful[c] & ~pop[c];
      adv_r[c]   = pop[c] | (set_ovf[c] & ~mode[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
      end
      ovf  <= '0;
      mode <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (flush[c]) begin
          wptr[c] <= '0;
          rptr[c] <= '0;
          ovf[c]  <= 1'b0;
        end else begin
          if (wr_mem[c]) wptr[c] <= wptr[c] + 1'b1;
          if (adv_r[c])  rptr[c] <= rptr[c] + 1'b1;
          if (set_ovf[c])      ovf[c] <= 1'b1;
          else if (ovf_clr[c]) ovf[c] <= 1'b0;
        end
        if (ctrl_we[c]) mode[c] <= bus.hwdata[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (wr_mem[c]) mem[c][wptr[c][AW-1:0]] <= wr_data[c*SWIDTH +: SWIDTH];
    end
  end

`ifdef AHB_FIFO_MC_IRQ_EN
  logic irq_cond, irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) thr_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (ctrl_we[c]) thr_q[c] <= bus.hwdata[15:8];
      end
    end
  end

  always_comb begin
    irq_cond = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (ovf[c] || (thr_q[c] != 8'd0 && 16'(cnt[c]) >= {8'd0, thr_q[c]})) irq_cond = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_cond;
  end

  assign irq = irq_q;
`else
  always_comb begin
    for (int c = 0; c < NCH; c++) thr_q[c] = '0;
  end

  assign irq = 1'b0;
`endif

  // Read mux; anything outside a valid read data phase returns zero
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_act && hit[c]) begin
        case (ap_reg)
          REG_DATA: if (!emp[c]) rdata = 32'h8000_0000 | 32'(mem[c][rptr[c][AW-1:0]]);
          REG_STAT: rdata = {13'd0, ovf[c], ful[c], emp[c], 16'(cnt[c])};
          REG_CTRL: rdata = {16'd0, thr_q[c], 7'd0, mode[c]};
          default:  rdata = '0;
        endcase
      end
    end
  end

  assign bus.hrdata    = rdata;
  assign bus.hreadyout = 1'b1;
  assign bus.hresp     = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.hsize, bus.htrans[0], bus.haddr[1:0], bus.hwdata};
endmodule
